load_store_unit: RTL and testbench

- Sequential, parametrised data-memory access unit between the execute stage and the data-memory bus.
- Accepts one load/store per handshake and computes the word-aligned address and byte enables.
- Steers store data onto byte lanes, extracts and extends load data from the addressed lane, and flags misaligned accesses and bus faults.
- Generalises the earlier combinational store/extend logic: XLEN 32 or 64, correct sign bit per access size, req/gnt/rvalid bus handshake, response timeout.

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/load_store_unit_ls_align.sv | 72 +++++++
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: funct3 op codes, FSM states and
// small helpers for lane offset width and access size.
package load_store_unit_pkg;

  localparam logic [2:0] LS_B_OP  = 3'b000;
  localparam logic [2:0] LS_H_OP  = 3'b001;
  localparam logic [2:0] LS_W_OP  = 3'b010;
  localparam logic [2:0] LS_D_OP  = 3'b011;
  localparam logic [2:0] LS_BU_OP = 3'b100;
  localparam logic [2:0] LS_HU_OP = 3'b101;
  localparam logic [2:0] LS_WU_OP = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } ls_state_e;

  // Width of the byte offset inside one bus word.
  function automatic int ls_off_w(input int xlen);
    return (xlen == 64) ? 3 : 2;
  endfunction

  // Byte-enable pattern for an access before it is shifted to its lane.
  function automatic logic [7:0] ls_size_mask(input logic [2:0] funct3);
    logic [7:0] mask;
    case (funct3[1:0])
      2'b00:   mask = 8'h01;
      2'b01:   mask = 8'h03;
      2'b10:   mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/load_store_unit_ls_align.sv
// Combinational datapath of the load/store unit: alignment/legality check,
// store lane steering and byte enables, load lane extraction and extension.
module ls_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = ls_off_w(XLEN),
  parameter int BW    = XLEN / 8
) (
  input  logic [2:0]       i_req_funct3,
  input  logic             i_req_is_store,
  input  logic [OFF_W-1:0] i_req_off,
  input  logic [XLEN-1:0]  i_req_wdata,
  output logic             o_req_misaligned,
  output logic [BW-1:0]    o_req_be,
  output logic [XLEN-1:0]  o_req_wdata,
  input  logic [2:0]       i_rsp_funct3,
  input  logic [OFF_W-1:0] i_rsp_off,
  input  logic [XLEN-1:0]  i_rsp_rdata,
  output logic [XLEN-1:0]  o_rsp_rdata
);

  localparam logic IS_RV64 = (XLEN == 64);

  logic [2:0]      off3;
  logic            legal;
  logic            aligned;
  logic [XLEN-1:0] shifted;

  always_comb begin
    off3    = 3'(i_req_off);
    legal   = 1'b1;
    aligned = 1'b1;
    case (i_req_funct3)
      LS_B_OP:  aligned = 1'b1;
      LS_H_OP:  aligned = ~off3[0];
      LS_W_OP:  aligned = (off3[1:0] == 2'b00);
      LS_D_OP: begin
        legal   = IS_RV64;
        aligned = (off3 == 3'b000);
      end
      LS_BU_OP: legal = ~i_req_is_store;
      LS_HU_OP: begin
        legal   = ~i_req_is_store;
        aligned = ~off3[0];
      end
      LS_WU_OP: begin
        legal   = ~i_req_is_store & IS_RV64;
        aligned = (off3[1:0] == 2'b00);
      end
      default:  legal = 1'b0;
    endcase
    o_req_misaligned = ~legal | ~aligned;
    // A rejected access never reaches the bus, so keep its enables quiet.
    o_req_be    = o_req_misaligned ? '0 : BW'(BW'(ls_size_mask(i_req_funct3)) << i_req_off);
    o_req_wdata = i_req_wdata << {i_req_off, 3'b000};
  end

  always_comb begin
    shifted = i_rsp_rdata >> {i_rsp_off, 3'b000};
    case (i_rsp_funct3)
      LS_B_OP:  o_rsp_rdata = XLEN'($signed(shifted[7:0]));
      LS_H_OP:  o_rsp_rdata = XLEN'($signed(shifted[15:0]));
      LS_W_OP:  o_rsp_rdata = XLEN'($signed(shifted[31:0]));
      LS_BU_OP: o_rsp_rdata = XLEN'(shifted[7:0]);
      LS_HU_OP: o_rsp_rdata = XLEN'(shifted[15:0]);
      LS_WU_OP: o_rsp_rdata = XLEN'(shifted[31:0]);
      default:  o_rsp_rdata = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access per handshake, drives a req/gnt/rvalid
// data-memory bus and returns an extended load result or a fault flag.
//
//   state   | meaning
//   IDLE    | ready for a new access
//   REQ     | bus request held until granted
//   RSP     | waiting for rvalid, timeout counter running
//   DONE    | one-cycle completion pulse with flags/rdata valid
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_is_store,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_done,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_misaligned,
  output logic              o_access_fault,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN/8-1:0] o_mem_be,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  input  logic              i_mem_err
);

  localparam int OFF_W = ls_off_w(XLEN);
  localparam int BW    = XLEN / 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  ls_state_e        state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             is_store_q, is_store_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic [BW-1:0]    mem_be_q, mem_be_d;
  logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             misaligned_q, misaligned_d;
  logic             fault_q, fault_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic             al_misaligned;
  logic [BW-1:0]    al_be;
  logic [XLEN-1:0]  al_wdata;
  logic [XLEN-1:0]  al_rdata;

  ls_align #(.XLEN(XLEN)) u_align (
    .i_req_funct3     (i_funct3),
    .i_req_is_store   (i_is_store),
    .i_req_off        (i_addr[OFF_W-1:0]),
    .i_req_wdata      (i_wdata),
    .o_req_misaligned (al_misaligned),
    .o_req_be         (al_be),
    .o_req_wdata      (al_wdata),
    .i_rsp_funct3     (funct3_q),
    .i_rsp_off        (off_q),
    .i_rsp_rdata      (i_mem_rdata),
    .o_rsp_rdata      (al_rdata)
  );

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    is_store_d   = is_store_q;
    off_d        = off_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    misaligned_d = misaligned_q;
    fault_d      = fault_q;
    to_cnt_d     = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          funct3_d     = i_funct3;
          is_store_d   = i_is_store;
          off_d        = i_addr[OFF_W-1:0];
          mem_addr_d   = {i_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
          mem_be_d     = al_be;
          mem_wdata_d  = al_wdata;
          misaligned_d = al_misaligned;
          fault_d      = 1'b0;
          state_d      = al_misaligned ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_mem_gnt) begin
          to_cnt_d = '0;
          state_d  = ST_RSP;
        end
      end
      ST_RSP: begin
        // rvalid wins over a timeout expiring in the same cycle.
        if (i_mem_rvalid) begin
          fault_d = i_mem_err;
          if (!is_store_q) begin
            rdata_d = al_rdata;
          end
          state_d = ST_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_q == TO_LAST) begin
            fault_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      funct3_q     <= '0;
      is_store_q   <= 1'b0;
      off_q        <= '0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      is_store_q   <= is_store_d;
      off_q        <= off_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      fault_q      <= fault_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign o_ready        = (state_q == ST_IDLE);
  assign o_done         = (state_q == ST_DONE);
  assign o_mem_req      = (state_q == ST_REQ);
  assign o_mem_we       = is_store_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_mem_be       = mem_be_q;
  assign o_mem_wdata    = mem_wdata_q;
  assign o_rdata        = rdata_q;
  assign o_misaligned   = misaligned_q;
  assign o_access_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: an XLEN=32 (TIMEOUT=4) and an XLEN=64 (TIMEOUT=8)
// instance share one stimulus set, selected by sel, against a behavioural model.
module tb_load_store_unit;

  localparam int T32 = 4;
  localparam int T64 = 8;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        valid;
  logic        is_store;
  logic [2:0]  f3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [63:0] mrdata;
  logic        merr;

  logic        ready32, done32, mis32, flt32, req32, we32;
  logic [31:0] rdata32, maddr32, mwd32;
  logic [3:0]  be32;
  logic        ready64, done64, mis64, flt64, req64, we64;
  logic [63:0] rdata64, maddr64, mwd64;
  logic [7:0]  be64;

  logic        ready, done, mis, flt, req, we;
  logic [63:0] rdata, maddr, mwd;
  logic [7:0]  be;

  int errors;
  int checks;
  logic [63:0] exp_last [2];

  load_store_unit #(.XLEN(32), .TIMEOUT(T32), .TO_W(3)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid & ~sel), .o_ready(ready32),
    .i_is_store(is_store), .i_funct3(f3), .i_addr(addr[31:0]), .i_wdata(wdata[31:0]),
    .o_done(done32), .o_rdata(rdata32), .o_misaligned(mis32), .o_access_fault(flt32),
    .o_mem_req(req32), .o_mem_we(we32), .o_mem_addr(maddr32), .o_mem_be(be32),
    .o_mem_wdata(mwd32), .i_mem_gnt(gnt & ~sel), .i_mem_rvalid(rvalid & ~sel),
    .i_mem_rdata(mrdata[31:0]), .i_mem_err(merr)
  );

  load_store_unit #(.XLEN(64), .TIMEOUT(T64), .TO_W(4)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid & sel), .o_ready(ready64),
    .i_is_store(is_store), .i_funct3(f3), .i_addr(addr), .i_wdata(wdata),
    .o_done(done64), .o_rdata(rdata64), .o_misaligned(mis64), .o_access_fault(flt64),
    .o_mem_req(req64), .o_mem_we(we64), .o_mem_addr(maddr64), .o_mem_be(be64),
    .o_mem_wdata(mwd64), .i_mem_gnt(gnt & sel), .i_mem_rvalid(rvalid & sel),
    .i_mem_rdata(mrdata), .i_mem_err(merr)
  );

  assign ready = sel ? ready64 : ready32;
  assign done  = sel ? done64  : done32;
  assign mis   = sel ? mis64   : mis32;
  assign flt   = sel ? flt64   : flt32;
  assign req   = sel ? req64   : req32;
  assign we    = sel ? we64    : we32;
  assign rdata = sel ? rdata64 : {32'b0, rdata32};
  assign maddr = sel ? maddr64 : {32'b0, maddr32};
  assign mwd   = sel ? mwd64   : {32'b0, mwd32};
  assign be    = sel ? be64    : {4'b0, be32};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit mdl_mis(input int xlen, input logic [2:0] f, input bit st,
                                 input logic [63:0] a);
    if (f == 3'b111) return 1'b1;
    if (st && f >= 3'b100) return 1'b1;
    if (xlen == 32 && (f == 3'b011 || f == 3'b110)) return 1'b1;
    return (int'(a[2:0]) % nbytes(f)) != 0;
  endfunction

  function automatic logic [63:0] mdl_load(input int xlen, input logic [2:0] f,
                                           input logic [63:0] a, input logic [63:0] rd);
    int off;
    int bits;
    logic [63:0] v;
    logic [63:0] m;
    off  = int'(a[2:0]) % (xlen / 8);
    bits = 8 * nbytes(f);
    if (xlen == 32) rd = rd & 64'hFFFF_FFFF;
    v = rd >> (8 * off);
    m = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
    v = v & m;
    if (f < 3'b100 && v[bits-1]) v = v | ~m;
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // One complete access. gd = REQ cycles before gnt, rd = RSP cycles before rvalid.
  task automatic run_txn(input bit s, input logic [2:0] t_f3, input bit t_st,
                         input logic [63:0] t_addr, input logic [63:0] t_wdata,
                         input logic [63:0] t_rdata, input int gd, input int rd,
                         input bit t_err, input bit never, input string tag);
    int xlen, tmo_lim, off, nb, exp_done, cyc;
    bit m, tmo, exp_req, seen, exp_flt;
    logic [63:0] a_m, exp_addr, lane_mask, exp_wd, xmask;
    logic [7:0]  exp_be;
    xlen    = s ? 64 : 32;
    tmo_lim = s ? T64 : T32;
    xmask   = (xlen == 32) ? 64'hFFFF_FFFF : '1;
    a_m     = t_addr & xmask;
    off     = int'(a_m[2:0]) % (xlen / 8);
    nb      = nbytes(t_f3);
    m       = mdl_mis(xlen, t_f3, t_st, a_m);
    tmo     = never || (rd >= tmo_lim);
    exp_addr = a_m - 64'(off);
    exp_be   = 8'(((16'd1 << nb) - 16'd1) << off);
    lane_mask = '0;
    for (int i = 0; i < 8; i++) if (exp_be[i]) lane_mask[8*i +: 8] = 8'hFF;
    exp_wd   = ((t_wdata & xmask) << (8 * off)) & lane_mask;
    exp_done = m ? 1 : (tmo ? 2 + gd + tmo_lim : 3 + gd + rd);
    exp_flt  = !m && (tmo || t_err);
    if (!m && !t_st && !tmo) exp_last[s] = mdl_load(xlen, t_f3, a_m, t_rdata);

    sel = s;
    @(posedge clk); #1;
    valid = 1'b1; f3 = t_f3; is_store = t_st; addr = t_addr; wdata = t_wdata;
    gnt = 1'b0; rvalid = 1'b0; merr = 1'b0; mrdata = {$urandom, $urandom};
    @(negedge clk);
    checks++;
    if ({ready, done} !== 2'b10) begin
      errors++;
      $display("FAIL %s ready_at_accept: got ready/done %b%b expected 10", tag, ready, done);
    end
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= exp_done + 4) begin
      @(posedge clk); #1;
      valid    = (cyc < exp_done) ? 1'($urandom_range(0, 1)) : 1'b0;
      f3       = 3'($urandom);
      is_store = 1'($urandom);
      addr     = {$urandom, $urandom};
      wdata    = {$urandom, $urandom};
      gnt      = 1'b0;
      rvalid   = 1'b0;
      merr     = 1'($urandom);
      mrdata   = {$urandom, $urandom};
      if (!m) begin
        if (cyc == 1 + gd) gnt = 1'b1;
        else if (cyc > 1 + gd && cyc < exp_done) gnt = 1'($urandom_range(0, 1));
        if (cyc < 2 + gd) rvalid = 1'($urandom_range(0, 1));
        if (!tmo && cyc == 2 + gd + rd) begin
          rvalid = 1'b1; merr = t_err; mrdata = t_rdata;
        end
      end
      @(negedge clk);
      exp_req = !m && cyc <= 1 + gd;
      checks++;
      if (req !== exp_req) begin
        errors++;
        $display("FAIL %s mem_req cyc %0d: got %b expected %b", tag, cyc, req, exp_req);
      end
      if (exp_req && req) begin
        checks++;
        if (maddr !== exp_addr || be !== exp_be || we !== t_st) begin
          errors++;
          $display("FAIL %s bus_ctrl cyc %0d: got addr %h be %h we %b expected addr %h be %h we %b",
                   tag, cyc, maddr, be, we, exp_addr, exp_be, t_st);
        end
        checks++;
        if ((mwd & lane_mask) !== exp_wd) begin
          errors++;
          $display("FAIL %s mem_wdata: got %h expected %h (lanes %h)", tag, mwd & lane_mask, exp_wd, lane_mask);
        end
      end
      if (done) begin
        seen = 1'b1;
        checks++;
        if (cyc != exp_done) begin
          errors++;
          $display("FAIL %s done_latency: got cycle %0d expected %0d", tag, cyc, exp_done);
        end
        checks++;
        if ({mis, flt} !== {m, exp_flt}) begin
          errors++;
          $display("FAIL %s flags: got mis/fault %b%b expected %b%b", tag, mis, flt, m, exp_flt);
        end
        checks++;
        if (rdata !== exp_last[s]) begin
          errors++;
          $display("FAIL %s rdata: got %h expected %h", tag, rdata, exp_last[s]);
        end
      end
      cyc++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s done_timeout: got no o_done expected one by cycle %0d", tag, exp_done);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready32, done32, req32, mis32, flt32, we32} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl32: got %b expected 100000", {ready32, done32, req32, mis32, flt32, we32});
    end
    checks++;
    if ({rdata32, maddr32, mwd32, be32} !== '0) begin
      errors++;
      $display("FAIL reset_data32: got %h %h %h %h expected all zero", rdata32, maddr32, mwd32, be32);
    end
    checks++;
    if ({ready64, done64, req64, mis64, flt64, we64} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl64: got %b expected 100000", {ready64, done64, req64, mis64, flt64, we64});
    end
    checks++;
    if ({rdata64, maddr64, mwd64, be64} !== '0) begin
      errors++;
      $display("FAIL reset_data64: got %h %h %h %h expected all zero", rdata64, maddr64, mwd64, be64);
    end
    rst_n = 1'b1;
    exp_last[0] = '0;
    exp_last[1] = '0;
  endtask

  task automatic test_store_byte();
    run_txn(0, 3'b000, 1, 64'h1003, 64'h0000_00AB, 64'h0, 0, 0, 0, 0, "sb_1003");
    run_txn(0, 3'b001, 1, 64'h1006, 64'hDEAD_BEEF, 64'h0, 0, 0, 0, 0, "sh_1006");
  endtask

  task automatic test_load_extend();
    run_txn(0, 3'b000, 0, 64'h2002, 64'h0, 64'h00F1_0000, 0, 0, 0, 0, "lb_2002");
    run_txn(0, 3'b100, 0, 64'h2002, 64'h0, 64'h00F1_0000, 0, 0, 0, 0, "lbu_2002");
    run_txn(0, 3'b001, 0, 64'h2002, 64'h0, 64'h8001_0000, 0, 0, 0, 0, "lh_2002");
    run_txn(0, 3'b101, 0, 64'h2002, 64'h0, 64'h8001_0000, 0, 0, 0, 0, "lhu_2002");
  endtask

  task automatic test_misaligned();
    run_txn(0, 3'b001, 0, 64'h2001, 64'h0, 64'h0, 0, 0, 0, 0, "lh_2001");
    run_txn(0, 3'b010, 1, 64'h2002, 64'h0, 64'h0, 0, 0, 0, 0, "sw_2002");
    run_txn(0, 3'b011, 0, 64'h2000, 64'h0, 64'h0, 0, 0, 0, 0, "ld_rv32");
    run_txn(0, 3'b100, 1, 64'h2000, 64'h0, 64'h0, 0, 0, 0, 0, "st_f3_100");
    run_txn(1, 3'b111, 0, 64'h2000, 64'h0, 64'h0, 0, 0, 0, 0, "f3_111");
  endtask

  task automatic test_wait_states();
    run_txn(0, 3'b010, 0, 64'h3000, 64'h0, 64'h8765_4321, 3, 2, 0, 0, "lw_wait32");
    run_txn(1, 3'b010, 0, 64'h3004, 64'h0, 64'h8765_4321_0000_0000, 3, 5, 0, 0, "lw_wait64");
  endtask

  task automatic test_timeout();
    run_txn(0, 3'b010, 0, 64'h5000, 64'h0, 64'h0, 0, 0, 0, 1, "lw_timeout");
    run_txn(0, 3'b010, 0, 64'h5000, 64'h0, 64'h1234_5678, 1, 3, 0, 0, "rvalid_at_limit");
    run_txn(0, 3'b010, 0, 64'h5000, 64'h0, 64'hCAFE_F00D, 0, 1, 1, 0, "lw_bus_err");
    run_txn(1, 3'b011, 1, 64'h5008, 64'h1, 64'h0, 2, 0, 1, 0, "sd_bus_err");
  endtask

  task automatic test_xlen64();
    run_txn(1, 3'b010, 0, 64'h4, 64'h0, 64'h8000_0000_0000_0000, 0, 0, 0, 0, "lw64_neg");
    run_txn(1, 3'b110, 0, 64'h4, 64'h0, 64'h8000_0000_0000_0000, 0, 0, 0, 0, "lwu64");
    run_txn(1, 3'b011, 0, 64'h10, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 0, 0, 0, "ld64");
    run_txn(1, 3'b000, 1, 64'h17, 64'h5A, 64'h0, 0, 0, 0, 0, "sb64_lane7");
  endtask

  task automatic test_back_to_back();
    run_txn(0, 3'b010, 1, 64'h6000, 64'h1111_2222, 64'h0, 0, 0, 0, 0, "b2b_sw");
    run_txn(0, 3'b010, 0, 64'h6004, 64'h0, 64'h7FFF_0001, 0, 0, 0, 0, "b2b_lw");
    run_txn(0, 3'b001, 0, 64'h6003, 64'h0, 64'h0, 0, 0, 0, 0, "b2b_mis");
    run_txn(0, 3'b000, 0, 64'h6001, 64'h0, 64'h0000_8000, 0, 0, 0, 0, "b2b_lb");
  endtask

  task automatic test_random(input bit s, input int n);
    logic [2:0]  r_f3;
    logic [63:0] r_addr;
    int          lim;
    lim = s ? T64 : T32;
    for (int i = 0; i < n; i++) begin
      r_f3   = 3'($urandom);
      r_addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~64'(nbytes(r_f3) - 1);
      run_txn(s, r_f3, 1'($urandom), r_addr, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, lim + 1),
              $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, "random");
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b1;
    @(posedge clk); #1;
    valid = 1'b1; f3 = 3'b010; is_store = 1'b0; addr = 64'h8; gnt = 1'b0; rvalid = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0; gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    @(negedge clk);
    rst_n  = 1'b0;
    rvalid = 1'b1;
    mrdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checks++;
    if ({ready, done, req, rdata} !== {3'b100, 64'h0}) begin
      errors++;
      $display("FAIL reset_mid: got ready/done/req %b%b%b rdata %h expected 100 rdata 0",
               ready, done, req, rdata);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %b expected 0", done);
    end
    rvalid = 1'b0;
    rst_n  = 1'b1;
    exp_last[0] = '0;
    exp_last[1] = '0;
    run_txn(1, 3'b000, 0, 64'h9, 64'h0, 64'h0000_0000_0000_9C00, 1, 1, 0, 0, "after_reset");
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; sel = 1'b0; valid = 1'b0; is_store = 1'b0; f3 = '0;
    addr = '0; wdata = '0; gnt = 1'b0; rvalid = 1'b0; mrdata = '0; merr = 1'b0;
    test_reset();
    test_store_byte();
    test_load_extend();
    test_misaligned();
    test_wait_states();
    test_timeout();
    test_xlen64();
    test_back_to_back();
    test_random(0, 150);
    test_random(1, 150);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
